// File: rtl/lcd_nibble_sequencer_pkg.sv
// Shared types and HD44780 constants for the 4-bit LCD write engine.
package lcd_nibble_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_PWR_WAIT = 3'd0,
    ST_SETUP    = 3'd1,
    ST_EN_HI    = 3'd2,
    ST_DELAY    = 3'd3,
    ST_IDLE     = 3'd4
  } state_e;

  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_HOME      = 8'h02;
  localparam logic [7:0] CMD_FUNC_4B2L = 8'h28;
  localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
  localparam logic [7:0] CMD_ENTRY     = 8'h06;
  localparam logic [7:0] CMD_DDRAM     = 8'h80;

  localparam logic [3:0] INIT_NIB_8BIT  = 4'h3;
  localparam logic [3:0] INIT_NIB_4BIT  = 4'h2;
  localparam logic [1:0] INIT_LAST_STEP = 2'd3;

  // Clear (0x01) and home (0x02/0x03) share the upper six bits and need the long wait.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
    return (rs == 1'b0) && (data[7:2] == CMD_HOME[7:2]);
  endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Down-counter: load N-1 on state entry, done while the count reads zero.
module lcd_delay_timer #(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/lcd_nibble_sequencer.sv
// HD44780 4-bit write engine: power-on init, then byte writes split into timed nibbles.
module lcd_nibble_sequencer
  import lcd_nibble_sequencer_pkg::*;
#(
  parameter int SETUP_CYC      = 2,
  parameter int EN_HIGH_CYC    = 8,
  parameter int NIBBLE_GAP_CYC = 32,
  parameter int CMD_WAIT_CYC   = 1400,
  parameter int CLR_WAIT_CYC   = 55000,
  parameter int INIT_WAIT_CYC  = 500000,
  parameter int CNT_W          = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_req,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  output logic       busy,
  output logic       init_done,
  output logic       lcd_enb,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [3:0] lcd_data,
  output state_e     dbg_state
);

  localparam logic [CNT_W-1:0] SETUP_VAL = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] EN_VAL    = CNT_W'(EN_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_VAL   = CNT_W'(NIBBLE_GAP_CYC - 1);
  localparam logic [CNT_W-1:0] CMD_VAL   = CNT_W'(CMD_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] CLR_VAL   = CNT_W'(CLR_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] INIT_VAL  = CNT_W'(INIT_WAIT_CYC - 1);

  state_e     state_q, state_d;
  logic [1:0] step_q, step_d;
  logic       nib_sel_q, nib_sel_d;
  logic       rs_q, rs_d;
  logic [7:0] byte_q, byte_d;
  logic       init_done_q, init_done_d;
  logic       ack_q, ack_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_load_mux;
  logic [CNT_W-1:0] tmr_val_mux;
  logic             tmr_done;

  logic [3:0]       cur_nib;
  logic [CNT_W-1:0] post_val;
  logic             in_xfer;

  // Reset reloads the power-on wait so PWR_WAIT lasts its full length after any reset.
  assign tmr_load_mux = reset | tmr_load;
  assign tmr_val_mux  = reset ? INIT_VAL : tmr_val;

  lcd_delay_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .load     (tmr_load_mux),
    .load_val (tmr_val_mux),
    .done     (tmr_done)
  );

  always_comb begin
    cur_nib  = INIT_NIB_8BIT;
    post_val = CMD_VAL;
    if (!init_done_q) begin
      cur_nib  = (step_q == INIT_LAST_STEP) ? INIT_NIB_4BIT : INIT_NIB_8BIT;
      post_val = step_q[1] ? CMD_VAL : CLR_VAL;
    end else if (!nib_sel_q) begin
      cur_nib  = byte_q[7:4];
      post_val = GAP_VAL;
    end else begin
      cur_nib  = byte_q[3:0];
      post_val = is_slow_cmd(rs_q, byte_q) ? CLR_VAL : CMD_VAL;
    end
  end

  // wr_req/wr_ack: requester holds wr_req with wr_rs/wr_data stable; the byte is
  // taken on the edge where wr_req=1 in IDLE, and wr_ack pulses the following cycle.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    nib_sel_d   = nib_sel_q;
    rs_d        = rs_q;
    byte_d      = byte_q;
    init_done_d = init_done_q;
    ack_d       = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    case (state_q)
      ST_PWR_WAIT: begin
        if (tmr_done) begin
          state_d  = ST_SETUP;
          tmr_load = 1'b1;
          tmr_val  = SETUP_VAL;
        end
      end
      ST_SETUP: begin
        if (tmr_done) begin
          state_d  = ST_EN_HI;
          tmr_load = 1'b1;
          tmr_val  = EN_VAL;
        end
      end
      ST_EN_HI: begin
        if (tmr_done) begin
          state_d  = ST_DELAY;
          tmr_load = 1'b1;
          tmr_val  = post_val;
        end
      end
      ST_DELAY: begin
        if (tmr_done) begin
          if (!init_done_q) begin
            if (step_q == INIT_LAST_STEP) begin
              state_d     = ST_IDLE;
              init_done_d = 1'b1;
            end else begin
              step_d   = step_q + 2'd1;
              state_d  = ST_SETUP;
              tmr_load = 1'b1;
              tmr_val  = SETUP_VAL;
            end
          end else if (!nib_sel_q) begin
            nib_sel_d = 1'b1;
            state_d   = ST_SETUP;
            tmr_load  = 1'b1;
            tmr_val   = SETUP_VAL;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_IDLE: begin
        if (init_done_q && wr_req) begin
          state_d   = ST_SETUP;
          rs_d      = wr_rs;
          byte_d    = wr_data;
          nib_sel_d = 1'b0;
          ack_d     = 1'b1;
          tmr_load  = 1'b1;
          tmr_val   = SETUP_VAL;
        end
      end
      default: begin
        state_d = ST_PWR_WAIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_PWR_WAIT;
      step_q      <= 2'd0;
      nib_sel_q   <= 1'b0;
      rs_q        <= 1'b0;
      byte_q      <= 8'h00;
      init_done_q <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      nib_sel_q   <= nib_sel_d;
      rs_q        <= rs_d;
      byte_q      <= byte_d;
      init_done_q <= init_done_d;
      ack_q       <= ack_d;
    end
  end

  assign in_xfer   = (state_q == ST_SETUP) || (state_q == ST_EN_HI) || (state_q == ST_DELAY);
  assign lcd_enb   = (state_q == ST_EN_HI);
  assign lcd_rs    = in_xfer & init_done_q & rs_q;
  assign lcd_data  = in_xfer ? cur_nib : 4'h0;
  assign lcd_rw    = 1'b0;
  assign busy      = (state_q != ST_IDLE);
  assign wr_ack    = ack_q;
  assign init_done = init_done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_lcd_nibble_sequencer.sv
// Self-checking bench for lcd_nibble_sequencer: cycle timeline model plus directed scenarios.
module tb_lcd_nibble_sequencer;
  import lcd_nibble_sequencer_pkg::*;

  localparam int SETUP = 2;
  localparam int EN    = 4;
  localparam int GAP   = 8;
  localparam int CMD   = 16;
  localparam int CLR   = 64;
  localparam int INIT  = 100;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_req = 1'b0;
  logic       wr_rs = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ack, busy, init_done, lcd_enb, lcd_rs, lcd_rw;
  logic [3:0] lcd_data;
  state_e     dbg_state;

  always #5 clk = ~clk;

  lcd_nibble_sequencer #(
    .SETUP_CYC(SETUP), .EN_HIGH_CYC(EN), .NIBBLE_GAP_CYC(GAP),
    .CMD_WAIT_CYC(CMD), .CLR_WAIT_CYC(CLR), .INIT_WAIT_CYC(INIT), .CNT_W(20)
  ) dut (
    .clk(clk), .reset(reset), .wr_req(wr_req), .wr_rs(wr_rs), .wr_data(wr_data),
    .wr_ack(wr_ack), .busy(busy), .init_done(init_done), .lcd_enb(lcd_enb),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data), .dbg_state(dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: per-cycle expected pin timeline ----------------
  // entry = {busy, init_done, enb, rs, data[3:0], ack}; empty queue means idle.
  logic [8:0] exp_q[$];
  bit m_valid = 1'b0;
  bit m_done  = 1'b0;

  function automatic logic [8:0] mk(input logic b, input logic d, input logic e,
                                    input logic r, input logic [3:0] n, input logic a);
    return {b, d, e, r, n, a};
  endfunction

  task automatic push_nibble(input logic d, input logic r, input logic [3:0] n,
                             input int wait_cyc, input logic first_ack);
    for (int i = 0; i < SETUP; i++) exp_q.push_back(mk(1'b1, d, 1'b0, r, n, first_ack && (i == 0)));
    for (int i = 0; i < EN; i++) exp_q.push_back(mk(1'b1, d, 1'b1, r, n, 1'b0));
    for (int i = 0; i < wait_cyc; i++) exp_q.push_back(mk(1'b1, d, 1'b0, r, n, 1'b0));
  endtask

  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete();
      m_valid = 1'b1;
      m_done  = 1'b0;
      for (int i = 0; i < INIT; i++) exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0));
      push_nibble(1'b0, 1'b0, 4'h3, CLR, 1'b0);
      push_nibble(1'b0, 1'b0, 4'h3, CLR, 1'b0);
      push_nibble(1'b0, 1'b0, 4'h3, CMD, 1'b0);
      push_nibble(1'b0, 1'b0, 4'h2, CMD, 1'b0);
    end else if (m_valid) begin
      if (exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) m_done = 1'b1;
      end else if (wr_req) begin
        push_nibble(1'b1, wr_rs, wr_data[7:4], GAP, 1'b1);
        push_nibble(1'b1, wr_rs, wr_data[3:0],
                    (!wr_rs && wr_data < 8'h04) ? CLR : CMD, 1'b0);
      end
    end
  end

  // ---------------- event recorder + per-cycle compare ----------------
  int cyc = 0;
  int rst_cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) rst_cyc <= cyc + 1;
  end

  int         rise_cyc[$];
  logic [3:0] rise_nib[$];
  logic       rise_rs[$];
  int         fall_cyc[$];
  int         ack_cyc[$];
  int         bfall_cyc[$];
  logic       prev_enb = 1'b0;
  logic       prev_busy = 1'b1;
  logic       prev_rs = 1'b0;
  logic [3:0] prev_data = 4'h0;

  always @(negedge clk) begin
    logic [8:0] e;
    if (m_valid) begin
      e = (exp_q.size() > 0) ? exp_q[0] : mk(1'b0, m_done, 1'b0, 1'b0, 4'h0, 1'b0);
      check("busy", busy, e[8]);
      check("init_done", init_done, e[7]);
      check("lcd_enb", lcd_enb, e[6]);
      check("lcd_rs", lcd_rs, e[5]);
      check("lcd_data", lcd_data, e[4:1]);
      check("wr_ack", wr_ack, e[0]);
      check("lcd_rw", lcd_rw, 1'b0);
      if (prev_enb && lcd_enb) begin
        check("rs_stable_in_e", lcd_rs, prev_rs);
        check("data_stable_in_e", lcd_data, prev_data);
      end
    end
    if (lcd_enb && !prev_enb) begin
      rise_cyc.push_back(cyc);
      rise_nib.push_back(lcd_data);
      rise_rs.push_back(lcd_rs);
    end
    if (!lcd_enb && prev_enb) fall_cyc.push_back(cyc);
    if (wr_ack === 1'b1) ack_cyc.push_back(cyc);
    if (!busy && prev_busy) bfall_cyc.push_back(cyc);
    prev_enb  = lcd_enb;
    prev_busy = busy;
    prev_rs   = lcd_rs;
    prev_data = lcd_data;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0: return init_done;
      1: return wr_ack;
      default: return busy;
    endcase
  endfunction

  task automatic wait_sig(input string name, input int sel, input logic level, input int limit);
    int n = 0;
    while (n < limit && sig(sel) !== level) begin
      step();
      n++;
    end
    check({"wait_", name}, sig(sel), level);
  endtask

  task automatic write_byte(input logic rs, input logic [7:0] d);
    wr_req  = 1'b1;
    wr_rs   = rs;
    wr_data = d;
    wait_sig("ack", 1, 1'b1, 50);
    wr_req = 1'b0;
    wait_sig("idle", 2, 1'b0, 400);
  endtask

  task automatic check_post_wait(input string name, input logic rs, input logic [7:0] d, input int w);
    write_byte(rs, d);
    check(name, bfall_cyc[$] - fall_cyc[$], w);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int base;
    int acks0;
    int n;

    // Power-on init with wr_req held high throughout.
    wr_req = 1'b1;
    repeat (3) step();
    check("rst_busy", busy, 1'b1);
    check("rst_init_done", init_done, 1'b0);
    check("rst_enb", lcd_enb, 1'b0);
    reset = 1'b0;
    wait_sig("init_done", 0, 1'b1, 600);
    wr_req = 1'b0;
    check("init_acks", ack_cyc.size(), 0);
    check("init_rises", rise_cyc.size(), 4);
    if (rise_cyc.size() >= 4) begin
      check("init_first_rise", rise_cyc[0] - rst_cyc, INIT + SETUP);
      check("init_gap0", rise_cyc[1] - rise_cyc[0], 70);
      check("init_gap1", rise_cyc[2] - rise_cyc[1], 70);
      check("init_gap2", rise_cyc[3] - rise_cyc[2], 22);
      check("init_nib0", rise_nib[0], 4'h3);
      check("init_nib3", rise_nib[3], 4'h2);
      check("init_rs3", rise_rs[3], 1'b0);
    end
    repeat (3) step();

    // Data write 0x41.
    base = rise_cyc.size();
    write_byte(1'b1, 8'h41);
    check("w41_rises", rise_cyc.size() - base, 2);
    if (rise_cyc.size() == base + 2) begin
      check("w41_nib_hi", rise_nib[base], 4'h4);
      check("w41_nib_lo", rise_nib[base + 1], 4'h1);
      check("w41_rs", rise_rs[base + 1], 1'b1);
      check("w41_latency", rise_cyc[base] - ack_cyc[$], SETUP);
      check("w41_e_width", fall_cyc[$] - rise_cyc[base + 1], EN);
      check("w41_nib_gap", rise_cyc[base + 1] - fall_cyc[$ - 1], GAP + SETUP);
    end
    check("w41_post_wait", bfall_cyc[$] - fall_cyc[$], 16);
    check("w41_acks", ack_cyc.size(), 1);

    // Post-command waits: clear vs other commands vs data.
    check_post_wait("clr_post_wait", 1'b0, CMD_CLEAR, 64);
    check_post_wait("ddram_post_wait", 1'b0, CMD_DDRAM, 16);
    check_post_wait("data01_post_wait", 1'b1, 8'h01, 16);
    check_post_wait("home_post_wait", 1'b0, CMD_HOME, 64);
    check_post_wait("entry_post_wait", 1'b0, CMD_ENTRY, 16);

    // Back-to-back: wr_req held, data changed in the ack cycle.
    base  = rise_cyc.size();
    acks0 = ack_cyc.size();
    wr_req  = 1'b1;
    wr_rs   = 1'b0;
    wr_data = CMD_FUNC_4B2L;
    wait_sig("b2b_ack1", 1, 1'b1, 50);
    wr_data = CMD_DISP_ON;
    step();
    wait_sig("b2b_ack2", 1, 1'b1, 400);
    wr_req = 1'b0;
    wait_sig("b2b_idle", 2, 1'b0, 400);
    repeat (3) step();
    check("b2b_acks", ack_cyc.size() - acks0, 2);
    check("b2b_rises", rise_cyc.size() - base, 4);
    if (rise_cyc.size() == base + 4) begin
      check("b2b_nib0", rise_nib[base], 4'h2);
      check("b2b_nib1", rise_nib[base + 1], 4'h8);
      check("b2b_nib2", rise_nib[base + 2], 4'h0);
      check("b2b_nib3", rise_nib[base + 3], 4'hC);
    end
    check("b2b_first_idle_accept", ack_cyc[$] - bfall_cyc[$ - 1], 1);

    // Reset during EN_HI of the low nibble.
    base  = rise_cyc.size();
    acks0 = ack_cyc.size();
    wr_req  = 1'b1;
    wr_rs   = 1'b1;
    wr_data = 8'h55;
    wait_sig("abort_ack", 1, 1'b1, 50);
    wr_req = 1'b0;
    n = 0;
    while (n < 200 && rise_cyc.size() < base + 2) begin
      step();
      n++;
    end
    check("abort_in_en_hi", lcd_enb, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_enb", lcd_enb, 1'b0);
    check("abort_busy", busy, 1'b1);
    check("abort_init_done", init_done, 1'b0);
    base = rise_cyc.size();
    wait_sig("reinit_done", 0, 1'b1, 600);
    repeat (3) step();
    check("abort_no_ack", ack_cyc.size() - acks0, 1);
    check("reinit_rises", rise_cyc.size() - base, 4);
    if (rise_cyc.size() == base + 4) begin
      check("reinit_first_rise", rise_cyc[base] - rst_cyc, INIT + SETUP);
      check("reinit_nib2", rise_nib[base + 2], 4'h3);
      check("reinit_nib3", rise_nib[base + 3], 4'h2);
    end

    // One more write after recovery.
    check_post_wait("after_reinit_post_wait", 1'b1, 8'h30, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
